// File: rtl/ct_fspu_fmt_pipe.sv
// One-stage FP format pipe: sign injection, FP<->int moves and fclass,
// with NaN-box checking of narrow operands and a valid/ready output stage.
module ct_fspu_fmt_pipe #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        ex1_vld,
    output logic        ex1_ready,
    input  logic [5:0]  ex1_op,
    input  logic        ex1_scalar,
    input  logic [63:0] ex1_oper0,
    input  logic [63:0] ex1_oper1,
    input  logic [63:0] mtvr_src0,
    input  logic        check_nan,
    input  logic        flush,
    output logic        ex2_vld,
    input  logic        ex2_ready,
    output logic [63:0] ex2_result,
    output logic        ex2_illegal
);

    localparam int W = 1 + EXP_W + FRAC_W;
    // Upper box bits; shifting by 64 leaves an empty mask, so W=64 never reports unboxed.
    localparam logic [63:0] BOX  = {64{1'b1}} << W;
    localparam logic [W-1:0] CNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    localparam logic [5:0] OP_FSGNJ  = 6'b000001;
    localparam logic [5:0] OP_FSGNJN = 6'b000010;
    localparam logic [5:0] OP_FSGNJX = 6'b000100;
    localparam logic [5:0] OP_FMVVF  = 6'b001000;
    localparam logic [5:0] OP_FMVFV  = 6'b010000;
    localparam logic [5:0] OP_FCLASS = 6'b100000;

    function automatic logic unboxed(input logic [63:0] x, input logic en);
        return en && ((x & BOX) != BOX);
    endfunction

    logic               accept;
    logic [W-1:0]       op0;
    logic               op1_sign;
    logic [W-1:0]       src;
    logic signed [W-1:0] raw0;
    logic [EXP_W-1:0]   exp0;
    logic [FRAC_W-1:0]  frac0;
    logic               sign0, exp_max, exp_zero, frac_zero;
    logic [9:0]         cls;
    logic [63:0]        res_nxt;
    logic               illegal_nxt;

    assign ex1_ready = !ex2_vld || ex2_ready;
    assign accept    = ex1_vld && ex1_ready && !flush;

    // Canonical NaN has a clear sign bit, so a replaced oper1 contributes sign 0.
    assign op0      = unboxed(ex1_oper0, ex1_scalar) ? CNAN : ex1_oper0[W-1:0];
    assign op1_sign = unboxed(ex1_oper1, ex1_scalar) ? 1'b0 : ex1_oper1[W-1];
    assign src      = unboxed(mtvr_src0, check_nan)  ? CNAN : mtvr_src0[W-1:0];
    assign raw0     = ex1_oper0[W-1:0];

    assign sign0     = op0[W-1];
    assign exp0      = op0[W-2:FRAC_W];
    assign frac0     = op0[FRAC_W-1:0];
    assign exp_max   = &exp0;
    assign exp_zero  = ~|exp0;
    assign frac_zero = ~|frac0;

    always_comb begin
        cls    = '0;
        cls[0] =  sign0 && exp_max && frac_zero;
        cls[1] =  sign0 && !exp_max && !exp_zero;
        cls[2] =  sign0 && exp_zero && !frac_zero;
        cls[3] =  sign0 && exp_zero && frac_zero;
        cls[4] = !sign0 && exp_zero && frac_zero;
        cls[5] = !sign0 && exp_zero && !frac_zero;
        cls[6] = !sign0 && !exp_max && !exp_zero;
        cls[7] = !sign0 && exp_max && frac_zero;
        cls[8] =  exp_max && !frac_zero && !frac0[FRAC_W-1];
        cls[9] =  exp_max && frac0[FRAC_W-1];
    end

    always_comb begin
        res_nxt     = '0;
        illegal_nxt = 1'b0;
        case (ex1_op)
            OP_FSGNJ:  res_nxt = BOX | 64'({op1_sign, op0[W-2:0]});
            OP_FSGNJN: res_nxt = BOX | 64'({~op1_sign, op0[W-2:0]});
            OP_FSGNJX: res_nxt = BOX | 64'({sign0 ^ op1_sign, op0[W-2:0]});
            OP_FMVVF:  res_nxt = BOX | 64'(src);
            OP_FMVFV:  res_nxt = 64'(raw0);
            OP_FCLASS: res_nxt = 64'(cls);
            default:   illegal_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            ex2_vld <= 1'b0;
        else if (flush)
            ex2_vld <= 1'b0;
        else if (accept)
            ex2_vld <= 1'b1;
        else if (ex2_ready)
            ex2_vld <= 1'b0;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex2_result  <= '0;
            ex2_illegal <= 1'b0;
        end else if (accept) begin
            ex2_result  <= res_nxt;
            ex2_illegal <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_ct_fspu_fmt_pipe.sv
// Directed bench for ct_fspu_fmt_pipe: half-precision instance plus a
// single-precision instance sharing the same stimulus.
module tb_ct_fspu_fmt_pipe;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        ex1_vld, ex1_scalar, check_nan, flush, ex2_ready;
    logic [5:0]  ex1_op;
    logic [63:0] oper0, oper1, src0;
    logic        rdy_h, vld_h, ill_h, rdy_s, vld_s, ill_s;
    logic [63:0] res_h, res_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ct_fspu_fmt_pipe u_half (
        .forever_cpuclk(clk), .cpurst_b(rst_b), .ex1_vld(ex1_vld), .ex1_ready(rdy_h),
        .ex1_op(ex1_op), .ex1_scalar(ex1_scalar), .ex1_oper0(oper0), .ex1_oper1(oper1),
        .mtvr_src0(src0), .check_nan(check_nan), .flush(flush), .ex2_vld(vld_h),
        .ex2_ready(ex2_ready), .ex2_result(res_h), .ex2_illegal(ill_h)
    );

    ct_fspu_fmt_pipe #(.EXP_W(8), .FRAC_W(23)) u_single (
        .forever_cpuclk(clk), .cpurst_b(rst_b), .ex1_vld(ex1_vld), .ex1_ready(rdy_s),
        .ex1_op(ex1_op), .ex1_scalar(ex1_scalar), .ex1_oper0(oper0), .ex1_oper1(oper1),
        .mtvr_src0(src0), .check_nan(check_nan), .flush(flush), .ex2_vld(vld_s),
        .ex2_ready(ex2_ready), .ex2_result(res_s), .ex2_illegal(ill_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] s, input logic sc, input logic cn);
        ex1_vld = 1'b1; ex1_op = op; oper0 = a; oper1 = b; src0 = s;
        ex1_scalar = sc; check_nan = cn;
    endtask

    localparam logic [63:0] BX = 64'hFFFF_FFFF_FFFF_0000;

    // fclass vectors for boxed half operands: {operand, expected mask}
    logic [63:0] cls_in  [6] = '{BX | 64'hFC00, BX | 64'h7C01, BX | 64'h8000,
                                 BX | 64'h0001, BX | 64'h7C00, BX | 64'h8200};
    logic [63:0] cls_exp [6] = '{64'h001, 64'h100, 64'h008, 64'h020, 64'h080, 64'h004};

    initial begin
        rst_b = 1'b0; ex1_vld = 1'b0; ex1_op = '0; ex1_scalar = 1'b0;
        oper0 = '0; oper1 = '0; src0 = '0; check_nan = 1'b0; flush = 1'b0; ex2_ready = 1'b1;
        #3;
        chk("rst_vld", {63'd0, vld_h}, 64'd0);
        chk("rst_res", res_h, 64'd0);
        chk("rst_ill", {63'd0, ill_h}, 64'd0);
        chk("rst_ready", {63'd0, rdy_h}, 64'd1);
        @(negedge clk); rst_b = 1'b1;
        step();

        // back-to-back ops, one per cycle
        drive(6'b000010, BX | 64'h3C00, BX | 64'h0000, '0, 1'b1, 1'b0); step();
        chk("fsgnjn_vld", {63'd0, vld_h}, 64'd1);
        chk("fsgnjn", res_h, 64'hFFFF_FFFF_FFFF_BC00);
        drive(6'b100000, 64'h3C00, '0, '0, 1'b1, 1'b0); step();
        chk("fclass_unboxed", res_h, 64'h200);
        drive(6'b100000, 64'h3C00, '0, '0, 1'b0, 1'b0); step();
        chk("fclass_nochk", res_h, 64'h040);
        drive(6'b010000, 64'h8001, '0, '0, 1'b1, 1'b0); step();
        chk("fmvfv_sext", res_h, 64'hFFFF_FFFF_FFFF_8001);
        drive(6'b000001, BX | 64'hBC00, BX | 64'h3C00, '0, 1'b1, 1'b0); step();
        chk("fsgnj", res_h, 64'hFFFF_FFFF_FFFF_3C00);
        drive(6'b000100, BX | 64'h3C00, BX | 64'h8000, '0, 1'b1, 1'b0); step();
        chk("fsgnjx", res_h, 64'hFFFF_FFFF_FFFF_BC00);
        drive(6'b000001, BX | 64'h3C00, 64'h8000, '0, 1'b1, 1'b0); step();
        chk("fsgnj_op1_unboxed", res_h, 64'hFFFF_FFFF_FFFF_3C00);
        drive(6'b001000, '0, '0, 64'h0000_0000_1234_5678, 1'b0, 1'b1); step();
        chk("fmvvf_chk_h", res_h, 64'hFFFF_FFFF_FFFF_7E00);
        chk("fmvvf_chk_s", res_s, 64'hFFFF_FFFF_7FC0_0000);
        drive(6'b001000, '0, '0, 64'h0000_0000_1234_5678, 1'b0, 1'b0); step();
        chk("fmvvf_h", res_h, 64'hFFFF_FFFF_FFFF_5678);
        chk("fmvvf_s", res_s, 64'hFFFF_FFFF_1234_5678);
        for (int i = 0; i < 6; i++) begin
            drive(6'b100000, cls_in[i], '0, '0, 1'b1, 1'b0); step();
            chk($sformatf("fclass_%0d", i), res_h, cls_exp[i]);
        end
        drive(6'b000011, BX | 64'h3C00, BX, '0, 1'b1, 1'b0); step();
        chk("multi_ill", {63'd0, ill_h}, 64'd1);
        chk("multi_res", res_h, 64'd0);
        drive(6'b000000, BX | 64'h3C00, BX, '0, 1'b1, 1'b0); step();
        chk("zero_ill", {63'd0, ill_h}, 64'd1);
        chk("zero_res", res_h, 64'd0);
        chk("zero_vld", {63'd0, vld_h}, 64'd1);
        ex1_vld = 1'b0; step();
        chk("drain_vld", {63'd0, vld_h}, 64'd0);
        chk("legal_after", {63'd0, ill_h}, 64'd1);

        // back-pressure: A held, B waits, then drain+accept in the same cycle
        drive(6'b000001, BX | 64'h1111, BX, '0, 1'b1, 1'b0); step();
        chk("bp_a_vld", {63'd0, vld_h}, 64'd1);
        ex2_ready = 1'b0;
        drive(6'b000001, BX | 64'h2222, BX, '0, 1'b1, 1'b0); #1;
        chk("bp_ready0", {63'd0, rdy_h}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_hold_%0d", i), res_h, BX | 64'h1111);
            chk($sformatf("bp_vld_%0d", i), {63'd0, vld_h}, 64'd1);
        end
        ex2_ready = 1'b1; #1;
        chk("bp_ready1", {63'd0, rdy_h}, 64'd1);
        step();
        chk("bp_b", res_h, BX | 64'h2222);
        chk("bp_b_vld", {63'd0, vld_h}, 64'd1);
        ex1_vld = 1'b0; step();
        chk("bp_empty", {63'd0, vld_h}, 64'd0);

        // flush with ex2 occupied and a new op offered
        drive(6'b000001, BX | 64'h3333, BX, '0, 1'b1, 1'b0); step();
        chk("fl_a_vld", {63'd0, vld_h}, 64'd1);
        ex2_ready = 1'b0;
        drive(6'b000001, BX | 64'h4444, BX, '0, 1'b1, 1'b0); flush = 1'b1; step();
        chk("fl_vld", {63'd0, vld_h}, 64'd0);
        flush = 1'b0; ex1_vld = 1'b0; ex2_ready = 1'b1; step();
        chk("fl_no_b_vld", {63'd0, vld_h}, 64'd0);
        chk("fl_no_b_res", res_h, BX | 64'h3333);

        // reset asserted while stalled
        drive(6'b000001, BX | 64'h5555, BX, '0, 1'b1, 1'b0); step();
        ex2_ready = 1'b0; ex1_vld = 1'b0; step();
        chk("rs_stall_vld", {63'd0, vld_h}, 64'd1);
        rst_b = 1'b0; #1;
        chk("rs_vld", {63'd0, vld_h}, 64'd0);
        chk("rs_res", res_h, 64'd0);
        chk("rs_res_s", res_s, 64'd0);
        @(negedge clk); rst_b = 1'b1; ex2_ready = 1'b1;
        drive(6'b000010, BX | 64'h3C00, BX, '0, 1'b1, 1'b0);
        step();
        chk("rs_first_vld", {63'd0, vld_h}, 64'd1);
        chk("rs_first_res", res_h, 64'hFFFF_FFFF_FFFF_BC00);
        ex1_vld = 1'b0; step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_fspu_fmt_pipe.md
CT_FSPU_FMT_PIPE -- requirements
Module: ct_fspu_fmt_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent width of the FP format.
REQ-002 SHALL have parameter FRAC_W, default 10, fraction width; format width W = 1+EXP_W+FRAC_W, legal W in {16,32,64}.
REQ-003 SHALL have port forever_cpuclk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port cpurst_b  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ex1_vld  in  1  operation valid.
REQ-006 SHALL have port ex1_ready  out  1  stage can accept.
REQ-007 SHALL have port ex1_op  in  6  one-hot {fclass, fmvfv(f->x), fmvvf(x->f), fsgnjx, fsgnjn, fsgnj} (bit5..bit0).
REQ-008 SHALL have port ex1_scalar  in  1  enable NaN-box check on oper0/oper1.
REQ-009 SHALL have ports ex1_oper0, ex1_oper1, mtvr_src0  in  64 each  FP operands / integer source.
REQ-010 SHALL have port check_nan  in  1  enable NaN-box check on mtvr_src0.
REQ-011 SHALL have port flush  in  1  kill accepted and incoming ops.
REQ-012 SHALL have ports ex2_vld out 1, ex2_ready in 1, ex2_result out 64, ex2_illegal out 1.

Function
REQ-013 SHALL accept an op when ex1_vld && ex1_ready && !flush; ex1_ready = !ex2_vld || ex2_ready (combinational, no dependency on ex1_vld).
REQ-014 SHALL present the result with ex2_vld=1 exactly one cycle after accept; latency 1, throughput 1/cycle without back-pressure.
REQ-015 SHALL hold ex2_vld, ex2_result, ex2_illegal stable while ex2_vld && !ex2_ready.
REQ-016 SHALL clear ex2_vld when ex2_ready=1 and no new accept in the same cycle; accept and drain in the same cycle SHALL replace the entry (ex2_vld stays 1).
REQ-017 SHALL, on flush, set ex2_vld=0 next cycle and not capture an ex1 op presented that cycle; flush has priority over every other event.
REQ-018 SHALL, when W<64, treat operand X as unboxed when its enable is set and X[63:W] is not all ones; unboxed operand SHALL be replaced by canonical NaN {0, EXP_W ones, 1, FRAC_W-1 zeros} (half: 16'h7e00). W=64: no check.
REQ-019 SHALL compute fsgnj {op1.sign, op0[W-2:0]}, fsgnjn {~op1.sign, op0[W-2:0]}, fsgnjx {op0.sign^op1.sign, op0[W-2:0]} on the post-check operands.
REQ-020 SHALL compute fmvvf as post-check mtvr_src0[W-1:0].
REQ-021 SHALL NaN-box fsgnj/fsgnjn/fsgnjx/fmvvf results: bits [63:W] all ones.
REQ-022 SHALL compute fmvfv as raw ex1_oper0[W-1:0] sign-extended from bit W-1 (no box check).
REQ-023 SHALL compute fclass on post-check oper0 as 10-bit mask, zero-extended to 64: bit0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN; exactly one bit set.
REQ-024 SHALL, when ex1_op is not one-hot (zero or multiple bits), capture ex2_result=0 and ex2_illegal=1; otherwise ex2_illegal=0.
REQ-025 SHALL register result and illegal flag only on accept; register enables gated by accept (no update on stall).

Reset
REQ-026 SHALL, while cpurst_b=0, force ex2_vld=0, ex2_result=0, ex2_illegal=0 asynchronously; ex1_ready=1 after reset.
REQ-027 SHALL drop any in-flight op on reset mid-operation; first op after release behaves per REQ-014.

Verification (default half format)
REQ-028 SHALL cover fsgnjn: oper0=64'hFFFF_FFFF_FFFF_3C00, oper1=64'hFFFF_FFFF_FFFF_0000, scalar=1 -> next cycle ex2_result=64'hFFFF_FFFF_FFFF_BC00, ex2_vld=1.
REQ-029 SHALL cover unboxed fclass: oper0=64'h0000_0000_0000_3C00, scalar=1 -> ex2_result=64'h200; scalar=0 -> 64'h040; fmvfv oper0=...8001 -> 64'hFFFF_FFFF_FFFF_8001.
REQ-030 SHALL cover back-pressure: ex2_ready=0 for 3 cycles with op A held in ex2 and op B offered -> ex1_ready=0, result A stable; ex2_ready=1 -> A drains and B accepted same cycle, B visible next cycle, order A,B, none lost or duplicated.
REQ-031 SHALL cover flush coincident with ex1_vld and ex2_vld=1 -> ex2_vld=0 next cycle, B never appears.
REQ-032 SHALL cover ex1_op=6'b000011 -> ex2_illegal=1, ex2_result=0; ex1_op=0 -> same.
REQ-033 SHALL cover cpurst_b asserted mid-stall -> outputs 0 immediately; parameter run EXP_W=8/FRAC_W=23 unboxed fmvvf with check_nan=1 -> 64'hFFFF_FFFF_7FC0_0000.
